inst_mem_responder: RTL and testbench

- Instruction-memory responder: the memory end of the fetch interface driven by the IF stage.
- Accepts one word-aligned fetch request at a time and answers after a programmable wait-state count.
- Holds the response under backpressure.
- Supports request abort on pipeline flush (branch taken) and a side load port for preloading program words.

---
 rtl/inst_mem_responder.sv | 125 ++++++++++++
 tb/tb_inst_mem_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_responder.sv
// Instruction-memory responder: one fetch at a time, fixed wait states, held response, flush abort, preload port.
// Optional misaligned-fetch flagging is enabled by defining INST_MEM_ALIGN_CHECK_EN.
module inst_mem_responder #(
    parameter int          DEPTH       = 1024,
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] NOP_WORD    = 32'hE1A00000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_addr,
    input  logic              req_abort,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_inst,
    output logic [31:0]       rsp_addr,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
`ifdef INST_MEM_ALIGN_CHECK_EN
    output logic              rsp_err,
`endif
    output logic [1:0]        state_dbg
);

    // Handshakes: a request transfers on an edge where req_valid & req_ready & !req_abort;
    // a response transfers on an edge where rsp_valid & rsp_ready & !req_abort.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [31:0] lat_addr;
    logic        accept;
    logic        enter_resp;
    logic [31:0] rd_addr;
    logic [31:0] rd_word;
    logic        rd_oor;
    logic        rd_bad;

    logic [31:0] mem [DEPTH];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid && !req_abort) begin
                    accept    = 1'b1;
                    cnt_nxt   = WAIT_INIT;
                    state_nxt = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (req_abort) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                    if (cnt == 4'd1) state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (req_abort || rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        enter_resp = (state_nxt == S_RESP) && (state != S_RESP);
    end

    // With zero wait states the read happens on the accepting edge, before lat_addr is loaded.
    assign rd_addr = (state == S_IDLE) ? req_addr : lat_addr;
    assign rd_word = mem[rd_addr[ADDR_W+1:2]];
    assign rd_oor  = |rd_addr[31:ADDR_W+2];
`ifdef INST_MEM_ALIGN_CHECK_EN
    assign rd_bad  = rd_oor | (|rd_addr[1:0]);
`else
    assign rd_bad  = rd_oor;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            lat_addr <= 32'd0;
            rsp_inst <= 32'd0;
            rsp_addr <= 32'd0;
`ifdef INST_MEM_ALIGN_CHECK_EN
            rsp_err  <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) lat_addr <= req_addr;
            if (enter_resp) begin
                rsp_inst <= rd_bad ? NOP_WORD : rd_word;
                rsp_addr <= rd_addr;
            end
`ifdef INST_MEM_ALIGN_CHECK_EN
            if (enter_resp)                rsp_err <= |rd_addr[1:0];
            else if (state_nxt != S_RESP)  rsp_err <= 1'b0;
`endif
        end
    end

    // Program store is never reset; a load on the RESP-entry edge lands after the read above.
    always_ff @(posedge clk) begin
        if (load_en) mem[load_addr] <= load_data;
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_inst_mem_responder.sv
// Bench for inst_mem_responder: vector table of fetches plus hand-written abort/reset/load-collision sequences.
// Build with INST_MEM_ALIGN_CHECK_EN defined to also cover rsp_err.
module tb_inst_mem_responder;

    localparam int          ADDR_W = 10;
    localparam int          WAITC  = 2;
    localparam logic [31:0] NOP    = 32'hE1A00000;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [31:0]       req_addr = 32'd0;
    logic              req_abort = 1'b0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [31:0]       rsp_inst;
    logic [31:0]       rsp_addr;
    logic              load_en = 1'b0;
    logic [ADDR_W-1:0] load_addr = '0;
    logic [31:0]       load_data = 32'd0;
    logic [1:0]        state_dbg;
`ifdef INST_MEM_ALIGN_CHECK_EN
    logic              rsp_err;
`endif

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    inst_mem_responder #(
        .DEPTH(1024), .ADDR_W(ADDR_W), .WAIT_CYCLES(WAITC), .NOP_WORD(NOP)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_abort(req_abort),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_inst(rsp_inst), .rsp_addr(rsp_addr),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
`ifdef INST_MEM_ALIGN_CHECK_EN
        .rsp_err(rsp_err),
`endif
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    typedef struct {
        logic              ld;
        logic [ADDR_W-1:0] ld_idx;
        logic [31:0]       ld_data;
        logic [31:0]       addr;
        int                stall;
        logic [31:0]       exp_inst;
        logic              exp_err;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic do_load(input logic [ADDR_W-1:0] idx, input logic [31:0] data);
        load_en = 1'b1; load_addr = idx; load_data = data;
        tick();
        load_en = 1'b0;
    endtask

    task automatic accept_req(input logic [31:0] addr, input string tag);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin tick(); n++; end
        check({tag, " req_ready before issue"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_addr = addr;
        tick();
        req_valid = 1'b0; req_addr = 32'd0;
    endtask

    task automatic fetch(input logic [31:0] addr, input int stall, input logic [31:0] exp_inst,
                         input logic exp_err, input string tag);
        int lat;
        logic stable;
        logic [31:0] held, exp_w;
        exp_q.push_back(exp_inst);
        accept_req(addr, tag);
        lat = 1;
        while (!rsp_valid && lat < 40) begin tick(); lat++; end
        check({tag, " latency"}, lat, WAITC + 1);
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        check({tag, " rsp_inst"}, rsp_inst, exp_w);
        check({tag, " rsp_addr"}, rsp_addr, addr);
`ifdef INST_MEM_ALIGN_CHECK_EN
        check({tag, " rsp_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
`else
        if (exp_err) $display("note: %s expects rsp_err but feature is not built", tag);
`endif
        held = rsp_inst;
        stable = 1'b1;
        for (int i = 0; i < stall; i++) begin
            tick();
            if (!rsp_valid || rsp_inst !== held || rsp_addr !== addr) stable = 1'b0;
        end
        if (stall > 0) check({tag, " hold under stall"}, {31'd0, stable}, 32'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, " rsp_valid after handshake"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, " req_ready after handshake"}, {31'd0, req_ready}, 32'd1);
`ifdef INST_MEM_ALIGN_CHECK_EN
        check({tag, " rsp_err idle"}, {31'd0, rsp_err}, 32'd0);
`endif
    endtask

    initial begin
        int seen;
        int n;
        logic mis_err;
`ifdef INST_MEM_ALIGN_CHECK_EN
        mis_err = 1'b1;
`else
        mis_err = 1'b0;
`endif
        //             ld    idx    ld_data        addr           stall exp_inst       err
        vecs[0] = '{1'b1, 10'd3,    32'hE3A01005, 32'h0000000C, 0, 32'hE3A01005, 1'b0};
        vecs[1] = '{1'b0, 10'd0,    32'h0,        32'h0000000C, 5, 32'hE3A01005, 1'b0};
        vecs[2] = '{1'b1, 10'd0,    32'hE3A00001, 32'h00000000, 0, 32'hE3A00001, 1'b0};
        vecs[3] = '{1'b0, 10'd0,    32'h0,        32'h00010000, 1, NOP,          1'b0};
        vecs[4] = '{1'b1, 10'd1023, 32'hDEADBEEF, 32'h00000FFC, 0, 32'hDEADBEEF, 1'b0};
        vecs[5] = '{1'b0, 10'd0,    32'h0,        32'h00001000, 0, NOP,          1'b0};
        vecs[6] = '{1'b0, 10'd0,    32'h0,        32'h0000000E, 2,
                    mis_err ? NOP : 32'hE3A01005, mis_err};
        vecs[7] = '{1'b1, 10'd5,    32'h11111111, 32'h00000014, 0, 32'h11111111, 1'b0};
        vecs[8] = '{1'b1, 10'd5,    32'h22222222, 32'h00000014, 0, 32'h22222222, 1'b0};

        // reset state while rst is held low
        repeat (2) @(posedge clk);
        #1;
        check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("reset req_ready", {31'd0, req_ready}, 32'd1);
        check("reset rsp_inst", rsp_inst, 32'd0);
        check("reset rsp_addr", rsp_addr, 32'd0);
        check("reset state", {30'd0, state_dbg}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].ld) do_load(vecs[i].ld_idx, vecs[i].ld_data);
            fetch(vecs[i].addr, vecs[i].stall, vecs[i].exp_inst, vecs[i].exp_err,
                  $sformatf("vec%0d", i));
        end

        // abort during WAIT: no response ever, then a normal fetch
        accept_req(32'h0000000C, "abort_wait");
        req_abort = 1'b1;
        tick();
        req_abort = 1'b0;
        check("abort_wait rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("abort_wait req_ready", {31'd0, req_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin tick(); if (rsp_valid) seen++; end
        check("abort_wait no pulse", seen, 0);
        fetch(32'h00000000, 0, 32'hE3A00001, 1'b0, "after_abort");

        // abort in RESP wins over rsp_ready
        accept_req(32'h0000000C, "abort_resp");
        n = 0;
        while (!rsp_valid && n < 40) begin tick(); n++; end
        check("abort_resp reached resp", {31'd0, rsp_valid}, 32'd1);
        req_abort = 1'b1; rsp_ready = 1'b1;
        tick();
        req_abort = 1'b0; rsp_ready = 1'b0;
        check("abort_resp rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("abort_resp state", {30'd0, state_dbg}, 32'd0);

        // abort in IDLE blocks acceptance
        req_valid = 1'b1; req_abort = 1'b1; req_addr = 32'h0000000C;
        tick();
        req_valid = 1'b0; req_abort = 1'b0;
        check("abort_idle state", {30'd0, state_dbg}, 32'd0);
        check("abort_idle req_ready", {31'd0, req_ready}, 32'd1);

        // load to the fetched word on the RESP-entry edge returns old data
        accept_req(32'h00000014, "collide");
        tick();
        load_en = 1'b1; load_addr = 10'd5; load_data = 32'h33333333;
        tick();
        load_en = 1'b0;
        check("collide rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("collide old data", rsp_inst, 32'h22222222);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        fetch(32'h00000014, 0, 32'h33333333, 1'b0, "collide_new");

        // async reset mid-WAIT drops the transaction, memory survives
        accept_req(32'h0000000C, "rst_wait");
        #1 rst = 1'b0;
        #1;
        check("rst_wait rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_wait req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("rst_release req_ready", {31'd0, req_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 5; i++) begin tick(); if (rsp_valid) seen++; end
        check("rst_wait no pulse", seen, 0);
        fetch(32'h0000000C, 0, 32'hE3A01005, 1'b0, "rst_refetch");

        check("scoreboard drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
